usb_axi_bridge: RTL and testbench

USB_AXI_BRIDGE -- requirements
Module: usb_axi_bridge

---
 rtl/usb_axi_pkg.sv | 44 ++++
 rtl/usb_axi_addr_dec.sv | 25 ++
 rtl/usb_axi_bridge.sv | 138 +++++++++++++
 tb/tb_usb_axi_bridge.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_axi_pkg.sv
// Shared types and constants for the USB register/buffer AXI4-Lite bridge:
// FSM states, address-window decode constants and AXI response codes.
package usb_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_EXEC,
    WR_RESP,
    RD_EXEC,
    RD_WAIT,
    RD_RESP
  } state_e;

  typedef enum logic [1:0] {
    RGN_REG,
    RGN_STAT,
    RGN_MEM,
    RGN_UNMAP
  } region_e;

  localparam logic [31:0] REG_BASE  = 32'h0000_0000;
  localparam logic [31:0] REG_MASK  = 32'hFFFF_FF00;
  localparam logic [31:0] STAT_BASE = 32'h0000_0100;
  localparam logic [31:0] STAT_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] MEM_BASE  = 32'h0000_0400;
  localparam logic [31:0] MEM_MASK  = 32'hFFFF_FC00;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Register writes with wstrb[0]=0 are silently dropped but still OKAY.
  function automatic logic [1:0] write_resp(input region_e rgn, input logic [3:0] strb);
    logic [1:0] resp;
    case (rgn)
      RGN_REG:  resp = RESP_OKAY;
      RGN_STAT: resp = RESP_SLVERR;
      RGN_MEM:  resp = (strb == 4'hF) ? RESP_OKAY : RESP_SLVERR;
      default:  resp = RESP_DECERR;
    endcase
    return resp;
  endfunction

endpackage

// File: rtl/usb_axi_addr_dec.sv
// Combinational AXI byte-address decoder into register / status / memory /
// unmapped windows; one instance per address channel.
module usb_axi_addr_dec
  import usb_axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 12
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  output region_e                   region
);

  logic [31:0] addr_ext;

  always_comb begin
    addr_ext = 32'(addr);
    region   = RGN_UNMAP;
    if ((addr_ext & REG_MASK) == REG_BASE)
      region = RGN_REG;
    else if ((addr_ext & STAT_MASK) == STAT_BASE)
      region = RGN_STAT;
    else if ((addr_ext & MEM_MASK) == MEM_BASE)
      region = RGN_MEM;
  end

endmodule

// File: rtl/usb_axi_bridge.sv
// AXI4-Lite slave bridging to the USB SIE register file and buffer memory
// port B. One transaction in flight; alternating priority between AW/W and AR.
module usb_axi_bridge
  import usb_axi_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_COL_WIDTH  = 32,
  parameter int AXI_ADDR_WIDTH = 12
) (
  input  logic                      SIE_clk,
  input  logic                      reset_SIE,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      Reg_WrEn,
  output logic [5:0]                Reg_Address,
  output logic [7:0]                Reg_WrData,
  output logic                      Reg_RdEn,
  input  logic [7:0]                Reg_RdData,
  output logic                      En_B,
  output logic [MEM_ADDR_WIDTH-1:0] addrB,
  output logic [MEM_COL_WIDTH-1:0]  dinB,
  input  logic [MEM_COL_WIDTH-1:0]  doutB,
  input  logic                      Data_toggle_RF
);

  state_e     state, state_nxt;
  region_e    aw_region, ar_region, region;
  logic       wr_prio;
  logic       grant_wr, grant_rd;
  logic [3:0] wstrb_q;

  usb_axi_addr_dec #(.AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)) u_aw_dec (
    .addr   (s_axi_awaddr),
    .region (aw_region)
  );

  usb_axi_addr_dec #(.AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)) u_ar_dec (
    .addr   (s_axi_araddr),
    .region (ar_region)
  );

  // Grant arbitration: a write needs AW and W together; ties alternate.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == IDLE && !reset_SIE) begin
      grant_wr = s_axi_awvalid && s_axi_wvalid && (wr_prio || !s_axi_arvalid);
      grant_rd = s_axi_arvalid && !grant_wr;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_wr)      state_nxt = WR_EXEC;
        else if (grant_rd) state_nxt = RD_EXEC;
      end
      WR_EXEC: state_nxt = WR_RESP;
      WR_RESP: if (s_axi_bready) state_nxt = IDLE;
      RD_EXEC: state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = RD_RESP;
      RD_RESP: if (s_axi_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and valids are gated by reset so an aborted transaction never leaks a pulse.
  always_comb begin
    s_axi_awready = grant_wr;
    s_axi_wready  = grant_wr;
    s_axi_arready = grant_rd;
    s_axi_bvalid  = (state == WR_RESP) && !reset_SIE;
    s_axi_rvalid  = (state == RD_RESP) && !reset_SIE;
    Reg_WrEn      = (state == WR_EXEC) && (region == RGN_REG) && wstrb_q[0] && !reset_SIE;
    En_B          = (state == WR_EXEC) && (region == RGN_MEM) && (wstrb_q == 4'hF) && !reset_SIE;
    Reg_RdEn      = (state == RD_EXEC) && (region == RGN_REG) && !reset_SIE;
  end

  always_ff @(posedge SIE_clk) begin
    if (reset_SIE) begin
      state       <= IDLE;
      wr_prio     <= 1'b1;
      region      <= RGN_UNMAP;
      wstrb_q     <= '0;
      Reg_Address <= '0;
      Reg_WrData  <= '0;
      addrB       <= '0;
      dinB        <= '0;
      s_axi_bresp <= RESP_OKAY;
      s_axi_rresp <= RESP_OKAY;
      s_axi_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant_wr) begin
        wr_prio     <= 1'b0;
        region      <= aw_region;
        wstrb_q     <= s_axi_wstrb;
        Reg_Address <= s_axi_awaddr[7:2];
        Reg_WrData  <= s_axi_wdata[7:0];
        addrB       <= s_axi_awaddr[MEM_ADDR_WIDTH+1:2];
        dinB        <= s_axi_wdata;
        s_axi_bresp <= write_resp(aw_region, s_axi_wstrb);
      end else if (grant_rd) begin
        wr_prio     <= 1'b1;
        region      <= ar_region;
        Reg_Address <= s_axi_araddr[7:2];
        addrB       <= s_axi_araddr[MEM_ADDR_WIDTH+1:2];
        s_axi_rresp <= (ar_region == RGN_UNMAP) ? RESP_DECERR : RESP_OKAY;
      end
      // Register and memory read data both arrive one cycle after the EXEC strobe.
      if (state == RD_WAIT) begin
        case (region)
          RGN_REG:  s_axi_rdata <= {24'h0, Reg_RdData};
          RGN_MEM:  s_axi_rdata <= doutB;
          RGN_STAT: s_axi_rdata <= {31'h0, Data_toggle_RF};
          default:  s_axi_rdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_axi_bridge.sv
// Directed plus randomized bench for usb_axi_bridge with a behavioural model
// of the register file, buffer memory and address map.
module tb_usb_axi_bridge;

  localparam int MAW = 8;
  localparam int MCW = 32;
  localparam int AAW = 12;

  logic            SIE_clk = 1'b0;
  logic            reset_SIE;
  logic [AAW-1:0]  s_axi_awaddr, s_axi_araddr;
  logic            s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0]     s_axi_wdata, s_axi_rdata;
  logic [3:0]      s_axi_wstrb;
  logic [1:0]      s_axi_bresp, s_axi_rresp;
  logic            s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic            s_axi_rvalid, s_axi_rready;
  logic            Reg_WrEn, Reg_RdEn, En_B, Data_toggle_RF;
  logic [5:0]      Reg_Address;
  logic [7:0]      Reg_WrData, Reg_RdData;
  logic [MAW-1:0]  addrB;
  logic [MCW-1:0]  dinB, doutB;

  always #5 SIE_clk = ~SIE_clk;

  usb_axi_bridge #(.MEM_ADDR_WIDTH(MAW), .MEM_COL_WIDTH(MCW), .AXI_ADDR_WIDTH(AAW)) dut (
    .SIE_clk(SIE_clk), .reset_SIE(reset_SIE),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .Reg_WrEn(Reg_WrEn), .Reg_Address(Reg_Address), .Reg_WrData(Reg_WrData),
    .Reg_RdEn(Reg_RdEn), .Reg_RdData(Reg_RdData),
    .En_B(En_B), .addrB(addrB), .dinB(dinB), .doutB(doutB),
    .Data_toggle_RF(Data_toggle_RF)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge SIE_clk) cyc <= cyc + 1;

  // Reference contents, as the address map says they should be.
  logic [7:0]  model_reg [64];
  logic [31:0] model_mem [256];

  // Environment-side storage driven only by the bridge's strobes.
  logic [7:0]  env_reg [64];
  logic [31:0] env_mem [256];
  logic        env_loaded = 1'b0;
  always @(posedge SIE_clk) begin
    if (reset_SIE && !env_loaded) begin
      for (int i = 0; i < 64; i++)  env_reg[i] <= model_reg[i];
      for (int i = 0; i < 256; i++) env_mem[i] <= model_mem[i];
      env_loaded <= 1'b1;
    end else begin
      if (En_B)     env_mem[addrB] <= dinB;
      if (Reg_WrEn) env_reg[Reg_Address] <= Reg_WrData;
    end
    doutB <= env_mem[addrB];
    if (Reg_RdEn) Reg_RdData <= env_reg[Reg_Address];
  end

  int n_wren = 0, n_enb = 0, n_rden = 0, excl_bad = 0;
  always begin
    @(negedge SIE_clk);
    #2;
    if (Reg_WrEn) n_wren++;
    if (En_B)     n_enb++;
    if (Reg_RdEn) n_rden++;
    if ((32'(Reg_WrEn) + 32'(Reg_RdEn) + 32'(En_B)) > 1 || (s_axi_bvalid && s_axi_rvalid))
      excl_bad++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_to(input string tag, input int n);
    n_cmp++;
    assert (n < 50) else begin
      n_bad++;
      $error("FAIL %s: observed timeout after %0d cycles expected handshake", tag, n);
    end
  endtask

  // 0 = register window, 1 = status, 2 = memory window, 3 = unmapped
  function automatic int region_of(input logic [11:0] a);
    if (a <= 12'h0FF) return 0;
    if (a >= 12'h100 && a <= 12'h103) return 1;
    if (a >= 12'h400 && a <= 12'h7FF) return 2;
    return 3;
  endfunction

  int          w_hs, w_bcyc, w_wait, r_hs, r_vcyc;
  logic [1:0]  w_resp, r_resp;
  logic [31:0] r_data, t1_dinb;
  logic        t1_wren, t1_enb, t1_rden;
  logic [5:0]  t1_raddr;
  logic [7:0]  t1_rwdata;
  logic [7:0]  t1_addrb;

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge SIE_clk);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    #1; n = 0;
    while (!(s_axi_awready && s_axi_wready) && n < 50) begin @(negedge SIE_clk); #1; n++; end
    chk_to("aw_w_handshake", n);
    w_wait = n; w_hs = cyc;
    @(negedge SIE_clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    #1;
    t1_wren = Reg_WrEn; t1_enb = En_B; t1_rden = Reg_RdEn;
    t1_raddr = Reg_Address; t1_rwdata = Reg_WrData; t1_dinb = dinB;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin @(negedge SIE_clk); #1; n++; end
    chk_to("bvalid_wait", n);
    w_bcyc = cyc; w_resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    @(negedge SIE_clk);
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, input int hold);
    int n;
    @(negedge SIE_clk);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    #1; n = 0;
    while (!s_axi_arready && n < 50) begin @(negedge SIE_clk); #1; n++; end
    chk_to("ar_handshake", n);
    r_hs = cyc;
    @(negedge SIE_clk);
    s_axi_arvalid = 1'b0;
    #1;
    t1_addrb = addrB; t1_rden = Reg_RdEn; t1_enb = En_B; t1_wren = Reg_WrEn;
    n = 0;
    while (!s_axi_rvalid && n < 50) begin @(negedge SIE_clk); #1; n++; end
    chk_to("rvalid_wait", n);
    r_vcyc = cyc; r_data = s_axi_rdata; r_resp = s_axi_rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge SIE_clk); #1;
      chk("rd_hold_rvalid", 32'(s_axi_rvalid), 32'd1);
      chk("rd_hold_rdata", s_axi_rdata, r_data);
      chk("rd_hold_rresp", 32'(s_axi_rresp), 32'(r_resp));
    end
    s_axi_rready = 1'b1;
    @(negedge SIE_clk);
    s_axi_rready = 1'b0;
  endtask

  task automatic write_chk(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int rg, b_wren, b_enb;
    logic [1:0] exp_resp;
    rg = region_of(a);
    exp_resp = (rg == 0) ? 2'b00 : (rg == 1) ? 2'b10 :
               (rg == 2) ? ((s == 4'hF) ? 2'b00 : 2'b10) : 2'b11;
    b_wren = n_wren; b_enb = n_enb;
    axi_write(a, d, s);
    chk("wr_bresp", 32'(w_resp), 32'(exp_resp));
    chk("wr_bvalid_latency", 32'(w_bcyc - w_hs), 32'd2);
    chk("wr_regwren_pulses", 32'(n_wren - b_wren), (rg == 0 && s[0]) ? 32'd1 : 32'd0);
    chk("wr_enb_pulses", 32'(n_enb - b_enb), (rg == 2 && s == 4'hF) ? 32'd1 : 32'd0);
    if (rg == 0 && s[0]) model_reg[a / 4] = d[7:0];
    if (rg == 2 && s == 4'hF) model_mem[(a - 12'h400) / 4] = d;
  endtask

  task automatic read_chk(input logic [11:0] a, input int hold);
    int rg, b_rden;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    rg = region_of(a);
    exp_r = (rg == 3) ? 2'b11 : 2'b00;
    exp_d = (rg == 0) ? {24'h0, model_reg[a / 4]} :
            (rg == 1) ? {31'h0, Data_toggle_RF} :
            (rg == 2) ? model_mem[(a - 12'h400) / 4] : 32'h0;
    b_rden = n_rden;
    axi_read(a, hold);
    chk("rd_rdata", r_data, exp_d);
    chk("rd_rresp", 32'(r_resp), 32'(exp_r));
    chk("rd_rvalid_latency", 32'(r_vcyc - r_hs), 32'd3);
    chk("rd_regrden_pulses", 32'(n_rden - b_rden), (rg == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, 32'({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                             s_axi_rvalid, Reg_WrEn, Reg_RdEn, En_B}), 32'd0);
    chk({tag, "_regaddr_wdata"}, 32'({Reg_Address, Reg_WrData}), 32'd0);
    chk({tag, "_addrb"}, 32'(addrB), 32'd0);
    chk({tag, "_dinb"}, dinB, 32'd0);
    chk({tag, "_resp"}, 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
    chk({tag, "_rdata"}, s_axi_rdata, 32'd0);
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int n, b_wren, hs_b;

    for (int i = 0; i < 64; i++)  model_reg[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) model_mem[i] = $urandom;
    model_mem[2] = 32'hDEADBEEF;

    reset_SIE = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; Data_toggle_RF = 1'b0;
    repeat (3) @(negedge SIE_clk);
    #1;
    chk_reset_outputs("in_reset");
    @(negedge SIE_clk);
    reset_SIE = 1'b0;
    #1;
    chk_reset_outputs("after_reset");

    // Register write: strobe at T+1 with decoded address/data, OKAY.
    write_chk(12'h014, 32'h0000_00A5, 4'h1);
    chk("regwr_t1_wren", 32'(t1_wren), 32'd1);
    chk("regwr_t1_addr", 32'(t1_raddr), 32'd5);
    chk("regwr_t1_data", 32'(t1_rwdata), 32'hA5);
    read_chk(12'h014, 0);

    // Memory read from word 2.
    read_chk(12'h408, 0);
    chk("memrd_t1_addrb", 32'(t1_addrb), 32'd2);
    chk("memrd_t1_enb", 32'(t1_enb), 32'd0);
    chk("memrd_rdata_direct", r_data, 32'hDEADBEEF);

    // Partial-strobe memory write, then full write and readback.
    write_chk(12'h400, 32'h1234_5678, 4'h3);
    write_chk(12'h404, 32'hCAFE_F00D, 4'hF);
    chk("memwr_t1_dinb", t1_dinb, 32'hCAFE_F00D);
    read_chk(12'h404, 0);
    read_chk(12'h400, 0);

    // Status window and unmapped accesses.
    Data_toggle_RF = 1'b1;
    read_chk(12'h100, 0);
    Data_toggle_RF = 1'b0;
    read_chk(12'h100, 1);
    write_chk(12'h100, 32'hFFFF_FFFF, 4'hF);
    write_chk(12'h800, 32'h5555_AAAA, 4'hF);
    write_chk(12'h018, 32'h0000_0033, 4'h2);
    read_chk(12'h018, 0);

    // Unmapped read with rready held low for 5 cycles.
    read_chk(12'h200, 5);

    // Randomized mixed traffic.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       a = 12'($urandom_range(0, 63) * 4);
        1:       a = 12'h100;
        2:       a = 12'(12'h400 + $urandom_range(0, 255) * 4);
        default: a = $urandom_range(0, 1) ? 12'(12'h200 + $urandom_range(0, 127) * 4)
                                          : 12'(12'h800 + $urandom_range(0, 511) * 4);
      endcase
      d = $urandom;
      s = ($urandom_range(0, 2) == 0) ? 4'($urandom) : ($urandom_range(0, 1) ? 4'hF : 4'h1);
      Data_toggle_RF = 1'($urandom);
      if ($urandom_range(0, 1)) write_chk(a, d, s);
      else read_chk(a, int'($urandom_range(0, 2)));
    end

    // Reset during WR_EXEC of a register write aborts it.
    b_wren = n_wren;
    @(negedge SIE_clk);
    s_axi_awaddr = 12'h020; s_axi_wdata = 32'h77; s_axi_wstrb = 4'h1;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    #1; n = 0;
    while (!s_axi_awready && n < 50) begin @(negedge SIE_clk); #1; n++; end
    chk_to("abort_handshake", n);
    @(negedge SIE_clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    reset_SIE = 1'b1;
    #1;
    chk("abort_t1_wren", 32'(Reg_WrEn), 32'd0);
    @(negedge SIE_clk);
    reset_SIE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge SIE_clk); #1;
      chk("abort_bvalid", 32'(s_axi_bvalid), 32'd0);
    end
    chk("abort_wren_pulses", 32'(n_wren - b_wren), 32'd0);
    write_chk(12'h024, 32'h0000_0042, 4'h1);
    chk("abort_idle_immediate_grant", 32'(w_wait), 32'd0);
    read_chk(12'h020, 0);

    // Simultaneous AW/W and AR right after reset: write then read.
    @(negedge SIE_clk);
    reset_SIE = 1'b1;
    @(negedge SIE_clk);
    reset_SIE = 1'b0;
    s_axi_awaddr = 12'h010; s_axi_wdata = 32'h3C; s_axi_wstrb = 4'h1;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_araddr = 12'h010; s_axi_arvalid = 1'b1;
    #1;
    chk("tie1_awready", 32'(s_axi_awready), 32'd1);
    chk("tie1_arready", 32'(s_axi_arready), 32'd0);
    @(negedge SIE_clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    #1; n = 0;
    while (!s_axi_bvalid && n < 50) begin
      chk("tie_ar_blocked", 32'(s_axi_arready), 32'd0);
      @(negedge SIE_clk); #1; n++;
    end
    chk_to("tie_bvalid", n);
    chk("tie_bresp", 32'(s_axi_bresp), 32'd0);
    s_axi_bready = 1'b1;
    hs_b = cyc;
    @(negedge SIE_clk);
    s_axi_bready = 1'b0;
    model_reg[4] = 8'h3C;
    #1; n = 0;
    while (!s_axi_arready && n < 50) begin @(negedge SIE_clk); #1; n++; end
    chk_to("tie2_arready", n);
    chk("tie2_after_bresp", 32'(cyc > hs_b), 32'd1);
    @(negedge SIE_clk);
    s_axi_arvalid = 1'b0;
    #1; n = 0;
    while (!s_axi_rvalid && n < 50) begin @(negedge SIE_clk); #1; n++; end
    chk_to("tie2_rvalid", n);
    chk("tie2_rdata", s_axi_rdata, {24'h0, model_reg[4]});
    s_axi_rready = 1'b1;
    @(negedge SIE_clk);
    s_axi_rready = 1'b0;

    repeat (2) @(negedge SIE_clk);
    chk("strobe_exclusive", 32'(excl_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
